// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-network partial-sum datapath: default widths,
// accumulator FSM encoding and the guard width used by the saturating adder.
package bnn_pkg;

    localparam int PSUM_W_DEF  = 5;
    localparam int ACC_W_DEF   = 13;
    localparam int SAT_GUARD_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_LAST  = 2'd2,
        ST_FLUSH = 2'd3
    } acc_state_t;

endpackage

// File: rtl/psum_buffer.sv
// Per-pixel partial-sum store: one synchronous write port and one asynchronous read
// port so it maps onto distributed RAM; contents are never reset.
module psum_buffer #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/xnor_psum_accumulator.sv
// Accumulates per-pixel XNOR partial sums across input channels with saturation and
// binarises the final sum against a per-output-channel threshold.
module xnor_psum_accumulator
    import bnn_pkg::*;
#(
    parameter int PSUM_W    = PSUM_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAP_DEPTH = 1024,
    parameter int CH_MAX    = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAP_DEPTH):0]    cfg_num_pix,
    input  logic [$clog2(CH_MAX):0]       cfg_num_ch,
    input  logic signed [ACC_W-1:0]       threshold,
    input  logic                          thr_invert,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [PSUM_W-1:0]      in_psum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_bit,
    output logic                          busy,
    output logic                          done
);

    localparam int PIX_W  = $clog2(MAP_DEPTH) + 1;
    localparam int CH_W   = $clog2(CH_MAX) + 1;
    localparam int ADDR_W = $clog2(MAP_DEPTH);
    localparam int SUM_W  = ACC_W + SAT_GUARD_W;

    localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(MAP_DEPTH);
    localparam logic [CH_W-1:0]  CH_MAX_V = CH_W'(CH_MAX);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    acc_state_t state_reg, state_next;

    logic [PIX_W-1:0]        num_pix_reg, num_pix_clamp;
    logic [CH_W-1:0]         num_ch_reg, num_ch_clamp;
    logic signed [ACC_W-1:0] threshold_reg;
    logic                    invert_reg;
    logic [PIX_W-1:0]        pix_cnt_reg;
    logic [CH_W-1:0]         ch_cnt_reg;
    logic                    out_valid_reg, out_bit_reg;

    logic                    xfer, pix_last, done_next;
    logic [ACC_W-1:0]        buf_rd;
    logic signed [ACC_W-1:0] acc_base, psum_ext, sum_sat;
    logic signed [SUM_W-1:0] sum_wide;
    logic                    out_bit_next;

    always_comb begin
        num_pix_clamp = cfg_num_pix;
        if (cfg_num_pix == '0) begin
            num_pix_clamp = PIX_W'(1);
        end else if (cfg_num_pix > PIX_MAX) begin
            num_pix_clamp = PIX_MAX;
        end
        num_ch_clamp = cfg_num_ch;
        if (cfg_num_ch == '0) begin
            num_ch_clamp = CH_W'(1);
        end else if (cfg_num_ch > CH_MAX_V) begin
            num_ch_clamp = CH_MAX_V;
        end
    end

    assign in_ready  = (state_reg == ST_ACCUM) ||
                       ((state_reg == ST_LAST) && (!out_valid_reg || out_ready));
    assign xfer      = in_valid && in_ready;
    assign pix_last  = (pix_cnt_reg == num_pix_reg - PIX_W'(1));
    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = out_valid_reg;
    assign out_bit   = out_bit_reg;
    assign done      = done_next;

    // Channel 0 adds to zero instead of the buffer, so stale contents are never read.
    assign acc_base = (ch_cnt_reg == '0) ? '0 : $signed(buf_rd);
    assign psum_ext = ACC_W'(in_psum);
    assign sum_wide = {acc_base[ACC_W-1], acc_base} + {psum_ext[ACC_W-1], psum_ext};

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        if (sum_wide[SUM_W-1] != sum_wide[SUM_W-2]) begin
            sum_sat = sum_wide[SUM_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // Strict comparisons: equality binarises to 0 in both polarities.
    assign out_bit_next = invert_reg ? (sum_sat < threshold_reg) : (sum_sat > threshold_reg);

    psum_buffer #(
        .DEPTH (MAP_DEPTH),
        .WIDTH (ACC_W)
    ) u_psum_buffer (
        .clk     (clk),
        .wr_en   (xfer && (state_reg == ST_ACCUM)),
        .wr_addr (pix_cnt_reg[ADDR_W-1:0]),
        .wr_data (sum_sat),
        .rd_addr (pix_cnt_reg[ADDR_W-1:0]),
        .rd_data (buf_rd)
    );

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_ch_clamp == CH_W'(1)) ? ST_LAST : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (xfer && pix_last && (ch_cnt_reg == num_ch_reg - CH_W'(2))) begin
                    state_next = ST_LAST;
                end
            end
            ST_LAST: begin
                if (xfer && pix_last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!out_valid_reg) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            num_pix_reg   <= PIX_W'(1);
            num_ch_reg    <= CH_W'(1);
            threshold_reg <= '0;
            invert_reg    <= 1'b0;
            pix_cnt_reg   <= '0;
            ch_cnt_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_bit_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && start) begin
                num_pix_reg   <= num_pix_clamp;
                num_ch_reg    <= num_ch_clamp;
                threshold_reg <= threshold;
                invert_reg    <= thr_invert;
                pix_cnt_reg   <= '0;
                ch_cnt_reg    <= '0;
            end else if (xfer) begin
                if (pix_last) begin
                    pix_cnt_reg <= '0;
                    ch_cnt_reg  <= ch_cnt_reg + CH_W'(1);
                end else begin
                    pix_cnt_reg <= pix_cnt_reg + PIX_W'(1);
                end
            end
            if (xfer && (state_reg == ST_LAST)) begin
                out_valid_reg <= 1'b1;
                out_bit_reg   <= out_bit_next;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xnor_psum_accumulator.sv
// Directed bench: hand-computed binarised results for several pass configurations,
// back-pressure, saturation (6-bit accumulator instance) and mid-pass reset.
module tb_xnor_psum_accumulator;

    localparam int PIX_W = 11;
    localparam int CH_W  = 9;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic [PIX_W-1:0]        cfg_num_pix = '0;
    logic [CH_W-1:0]         cfg_num_ch = '0;
    logic signed [12:0]      threshold = '0;
    logic signed [5:0]       sat_threshold = '0;
    logic                    thr_invert = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [4:0]       in_psum = '0;
    logic                    out_ready = 1'b1;
    logic                    in_ready, out_valid, out_bit, busy, done;
    logic                    sat_in_ready, sat_out_valid, sat_out_bit, sat_busy, sat_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int pix_psum[4];
    int exp_bits[4];
    int got_bits[$];
    int got_sat[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    xnor_psum_accumulator u_dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_pix(cfg_num_pix), .cfg_num_ch(cfg_num_ch),
        .threshold(threshold), .thr_invert(thr_invert), .in_valid(in_valid), .in_ready(in_ready),
        .in_psum(in_psum), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .busy(busy), .done(done)
    );

    // Same control path as u_dut, so it runs in lockstep; only its datapath width differs.
    xnor_psum_accumulator #(.ACC_W(6)) u_sat (
        .clk(clk), .rst(rst), .start(start), .cfg_num_pix(cfg_num_pix), .cfg_num_ch(cfg_num_ch),
        .threshold(sat_threshold), .thr_invert(thr_invert), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_psum(in_psum), .out_valid(sat_out_valid), .out_ready(out_ready), .out_bit(sat_out_bit),
        .busy(sat_busy), .done(sat_done)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic send(input int v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_psum  = 5'(v);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_pass(input string name, input int npix, input int nch, input int thr,
                            input int sat_thr, input int inv, input int nres, input int stall,
                            input int poke);
        int eff_pix, eff_ch, done_before, n;
        eff_pix = (npix == 0) ? 1 : npix;
        eff_ch  = (nch == 0) ? 1 : nch;
        got_bits.delete();
        got_sat.delete();
        done_before = done_cnt;
        @(posedge clk);
        #1;
        cfg_num_pix   = PIX_W'(npix);
        cfg_num_ch    = CH_W'(nch);
        threshold     = 13'(thr);
        sat_threshold = 6'(sat_thr);
        thr_invert    = inv[0];
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fork
            begin
                for (int c = 0; c < eff_ch; c++) begin
                    for (int p = 0; p < eff_pix; p++) begin
                        if (poke != 0 && c == 1 && p == 0) begin
                            start       = 1'b1;
                            cfg_num_pix = PIX_W'(1);
                            cfg_num_ch  = CH_W'(1);
                        end
                        send(pix_psum[p]);
                        start = 1'b0;
                    end
                end
            end
            begin
                for (int r = 0; r < nres; r++) begin
                    int w;
                    w = 0;
                    @(negedge clk);
                    while (!(out_valid && out_ready) && w < 300) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 300) begin
                        check_eq({name, "_out_timeout"}, 0, 1);
                        break;
                    end
                    got_bits.push_back(int'(out_bit));
                    got_sat.push_back(int'(sat_out_bit));
                end
            end
            begin
                if (stall != 0) begin
                    int w;
                    w = 0;
                    @(negedge clk);
                    while (!out_valid && w < 300) begin
                        @(negedge clk);
                        w++;
                    end
                    @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        check_eq({name, "_stall_in_ready"}, 32'(in_ready), 0);
                        check_eq({name, "_stall_out_valid"}, 32'(out_valid), 1);
                        check_eq({name, "_stall_out_bit"}, 32'(out_bit), exp_bits[1]);
                    end
                    @(posedge clk);
                    #1;
                    out_ready = 1'b1;
                end
            end
        join
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({name, "_busy_end"}, 32'(busy), 0);
        check_eq({name, "_done_pulses"}, done_cnt - done_before, 1);
        check_eq({name, "_nres"}, got_bits.size(), nres);
        for (int i = 0; i < nres && i < got_bits.size(); i++) begin
            check_eq($sformatf("%s_bit%0d", name, i), got_bits[i], exp_bits[i]);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_in_ready", 32'(in_ready), 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_bit", 32'(out_bit), 0);
        check_eq("rst_done", 32'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // acc {3,6,-9,12} vs 5; a stray start mid-pass must be ignored
        pix_psum = '{1, 2, -3, 4};
        exp_bits = '{0, 1, 0, 1};
        run_pass("basic", 4, 3, 5, 0, 0, 4, 0, 1);

        exp_bits = '{0, 0, 1, 0};
        run_pass("invert", 4, 3, 0, 0, 1, 4, 0, 0);

        exp_bits = '{0, 1, 0, 1};
        run_pass("stall", 4, 3, 5, 0, 0, 4, 1, 0);

        pix_psum = '{5, 0, 0, 0};
        exp_bits = '{0, 0, 0, 0};
        run_pass("single_eq", 1, 1, 5, 0, 0, 1, 0, 0);
        exp_bits = '{1, 0, 0, 0};
        run_pass("single_gt", 1, 1, 4, 0, 0, 1, 0, 0);
        run_pass("cfg_zero", 0, 0, 4, 0, 0, 1, 0, 0);

        // 4 x 15: 13-bit acc gives 60; 6-bit acc must stick at 31
        pix_psum = '{15, 0, 0, 0};
        exp_bits = '{1, 0, 0, 0};
        run_pass("sat_hi", 1, 4, 59, 30, 0, 1, 0, 0);
        check_eq("sat_bit_thr30", got_sat.size() > 0 ? got_sat[0] : -1, 1);
        run_pass("sat_eq", 1, 4, 59, 31, 0, 1, 0, 0);
        check_eq("sat_bit_thr31", got_sat.size() > 0 ? got_sat[0] : -1, 0);

        // abort in the middle of channel 1, then a clean pass with different sizes
        pix_psum = '{1, 2, -3, 4};
        @(posedge clk);
        #1;
        cfg_num_pix = PIX_W'(4);
        cfg_num_ch  = CH_W'(3);
        threshold   = 13'sd5;
        thr_invert  = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) send(pix_psum[i % 4]);
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_in_ready", 32'(in_ready), 0);
        check_eq("midrst_out_valid", 32'(out_valid), 0);
        check_eq("midrst_done", 32'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_psum = '{7, -2, 0, 0};
        exp_bits = '{1, 0, 0, 0};
        run_pass("restart", 2, 2, 0, 0, 0, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xnor_psum_accumulator.md
XNOR_PSUM_ACCUMULATOR -- requirements
Module: xnor_psum_accumulator

Interface
REQ-001 Parameter PSUM_W, default 5: signed width of per-pixel partial sum from PE array.
REQ-002 Parameter ACC_W, default 13: signed accumulator width; SHALL satisfy ACC_W >= PSUM_W + clog2(CH_MAX).
REQ-003 Parameter MAP_DEPTH, default 1024: maximum pixels per output map (buffer entries).
REQ-004 Parameter CH_MAX, default 256: maximum input channels accumulated per output channel.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse; latches cfg_* and threshold inputs, begins a pass set.
REQ-008 cfg_num_pix  input  clog2(MAP_DEPTH)+1  pixels per map, 1..MAP_DEPTH.
REQ-009 cfg_num_ch  input  clog2(CH_MAX)+1  input channels, 1..CH_MAX.
REQ-010 threshold  input  ACC_W signed  binarisation threshold for this output channel.
REQ-011 thr_invert  input  1  0: out = acc > threshold; 1: out = acc < threshold (negative BN scale).
REQ-012 in_valid / in_ready  input / output  1 / 1  partial-sum handshake.
REQ-013 in_psum  input  PSUM_W signed  partial sum for current pixel, current channel.
REQ-014 out_valid / out_ready  output / input  1 / 1  binary-result handshake.
REQ-015 out_bit  output  1  binarised activation.
REQ-016 busy / done  output / output  1 / 1  pass set active; one-cycle completion pulse.

Function
REQ-017 FSM states IDLE, ACCUM, LAST, FLUSH; IDLE->ACCUM on start (LAST if cfg_num_ch==1); ACCUM->LAST after final pixel of channel cfg_num_ch-2; LAST->FLUSH after final pixel accepted; FLUSH->IDLE when out_valid clears, asserting done for one cycle.
REQ-018 Transfer occurs when in_valid && in_ready; pixel counter wraps 0..cfg_num_pix-1, channel counter increments on wrap.
REQ-019 Channel 0: buffer[pix] <= sign-extended in_psum (no read of stale data).
REQ-020 Channels 1..cfg_num_ch-2: buffer[pix] <= buffer[pix] + in_psum.
REQ-021 Last channel: sum = buffer[pix] + in_psum (channel 0 if cfg_num_ch==1); buffer not written; out_bit and out_valid registered next cycle (latency 1).
REQ-022 in_ready SHALL be 1 in ACCUM; in LAST equal to (!out_valid || out_ready); 0 in IDLE and FLUSH.
REQ-023 out_valid held with out_bit stable until out_ready; no result dropped or duplicated.
REQ-024 Accumulation saturates at ACC_W signed limits; no wrap-around.
REQ-025 Equality with threshold yields out_bit=0 in both modes.
REQ-026 start while busy SHALL be ignored.
REQ-027 cfg values of 0 treated as 1; values above maximum clamped.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 On rst low, immediately: state IDLE, counters 0, in_ready 0, out_valid 0, out_bit 0, busy 0, done 0.
REQ-030 Buffer contents need not reset; channel-0 overwrite guarantees correctness.
REQ-031 Reset mid-pass aborts silently; next start begins a clean pass set.

Structure
REQ-032 Shared package bnn_pkg holds PSUM_W/ACC_W defaults, FSM state encoding, and saturating-add width constants.
REQ-033 One sub-module psum_buffer: MAP_DEPTH x ACC_W, one write port, one combinational/async read port, no reset.
REQ-034 Target 120-400 RTL lines; synthesisable to LUTRAM or registers.

Verification
REQ-035 num_pix=4, num_ch=3, psum per pixel {1,2,-3,4} each channel, threshold=5, invert=0 -> acc {3,6,-9,12}, out_bit 0,1,0,1, done once.
REQ-036 Same, invert=1, threshold=0 -> out_bit 0,0,1,0.
REQ-037 num_ch=1, psum 5, threshold 5 -> out_bit 0 (equality); threshold 4 -> 1.
REQ-038 out_ready low 10 cycles during LAST -> in_ready low, out_valid/out_bit stable, all 4 results delivered in order.
REQ-039 ACC_W=6, num_ch=4, psum=15 per channel -> acc saturates at 31, not wrapped negative.
REQ-040 rst asserted mid-ACCUM -> outputs zero same cycle; restart with new cfg -> correct results, no residue.
